// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the simulation UART character
// channel.
//   UART_DATA_BITS / UART_START_BIT / UART_STOP_BIT / UART_IDLE : 8N1 framing
//   tx_state_e    : transmit FSM state encoding
//   SIM_UART_ADDR : store address decoded by the data-memory model
package uart_pkg;

    localparam int          UART_DATA_BITS = 8;
    localparam logic        UART_START_BIT = 1'b0;
    localparam logic        UART_STOP_BIT  = 1'b1;
    localparam logic        UART_IDLE      = 1'b1;
    localparam logic [63:0] SIM_UART_ADDR  = 64'h1000_0000;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_char_tx_char_fifo.sv
// char_fifo: synchronous character FIFO with an explicit occupancy count.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write din at the edge (caller guarantees space or a same-edge pop)
//   pop      : retire the head at the edge (caller guarantees non-empty)
//   dout     : current head, combinational read
//   count    : entries held; empty : count == 0
// Pointers are log2(DEPTH) bits and wrap on their own, so full/empty are
// told apart by the separate count.
module char_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = UART_DATA_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_char_tx.sv
// uart_char_tx: buffers single-cycle character strobes from the UART store
// path and serialises each as an 8N1 frame (start, 8 data LSB first, stop).
//   clk, rst     : clock, asynchronous active-high reset
//   char_in      : character, valid when char_valid is high
//   char_valid   : one-cycle strobe, never stalled
//   overflow_clr : clears the sticky overflow flag (a same-cycle drop wins)
//   tx           : serial line, idle high, registered
//   busy         : high while a frame is on the line, registered
//   overflow     : sticky, a character was dropped on a full buffer
//   fifo_count   : characters waiting, excluding the one on the line
module uart_char_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [UART_DATA_BITS-1:0]       char_in,
    input  logic                            char_valid,
    input  logic                            overflow_clr,
    output logic                            tx,
    output logic                            busy,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int BW = $clog2(CLK_DIV);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int IW = $clog2(UART_DATA_BITS);

    tx_state_e                 state, state_d;
    logic [BW-1:0]             baud;
    logic [IW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic [UART_DATA_BITS-1:0] head;
    logic                      empty;
    logic                      boundary;
    logic                      last_bit;
    logic                      pop;
    logic                      push;
    logic                      tx_d;
    logic                      busy_d;
    logic                      shift_en;

    // A bit period ends on the cycle the baud counter sits at zero.
    assign boundary = (state != IDLE) && (baud == '0);
    assign last_bit = (bit_idx == IW'(UART_DATA_BITS-1));

    // Pop from IDLE, or at the end of a stop bit to chain frames gap-free.
    assign pop  = !empty && ((state == IDLE) || ((state == STOP) && boundary));
    // A full buffer still accepts when the head leaves at the same edge.
    assign push = char_valid && ((fifo_count < CW'(FIFO_DEPTH)) || pop);

    char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (UART_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (char_in),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .empty (empty)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (!empty)               state_d = START;
            START:   if (boundary)             state_d = DATA;
            DATA:    if (boundary && last_bit) state_d = STOP;
            STOP:    if (boundary)             state_d = empty ? IDLE : START;
            default:                           state_d = IDLE;
        endcase
    end

    // Output logic: next values for the registered line and busy flag.
    // The shift register is pre-shifted, so shift[0] is always the next bit.
    always_comb begin
        tx_d     = tx;
        busy_d   = busy;
        shift_en = 1'b0;
        case (state)
            IDLE: begin
                tx_d   = UART_IDLE;
                busy_d = 1'b0;
                if (!empty) begin
                    tx_d   = UART_START_BIT;
                    busy_d = 1'b1;
                end
            end
            START: begin
                if (boundary) begin
                    tx_d     = shift[0];
                    shift_en = 1'b1;
                end
            end
            DATA: begin
                if (boundary) begin
                    tx_d     = last_bit ? UART_STOP_BIT : shift[0];
                    shift_en = 1'b1;
                end
            end
            STOP: begin
                if (boundary) begin
                    if (!empty) begin
                        tx_d = UART_START_BIT;
                    end else begin
                        tx_d   = UART_IDLE;
                        busy_d = 1'b0;
                    end
                end
            end
            default: begin
                tx_d   = UART_IDLE;
                busy_d = 1'b0;
            end
        endcase
    end

    // Line, baud counter, bit index and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx      <= UART_IDLE;
            busy    <= 1'b0;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            tx   <= tx_d;
            busy <= busy_d;
            if (pop) begin
                shift <= head;
                baud  <= BW'(CLK_DIV-1);
            end else if (state != IDLE) begin
                baud <= (baud == '0) ? BW'(CLK_DIV-1) : baud - BW'(1);
                if (shift_en) shift <= shift >> 1;
            end
            if ((state == START) && boundary)     bit_idx <= '0;
            else if ((state == DATA) && boundary) bit_idx <= bit_idx + IW'(1);
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      overflow <= 1'b0;
        else if (char_valid && !push) overflow <= 1'b1;
        else if (overflow_clr)        overflow <= 1'b0;
    end

endmodule

// File: tb/tb_uart_char_tx.sv
module tb_uart_char_tx;

    localparam int CD    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int FLEN  = 10 * CD;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    char_in = 8'h00;
    logic          char_valid = 1'b0;
    logic          overflow_clr = 1'b0;
    logic          tx;
    logic          busy;
    logic          overflow;
    logic [CW-1:0] fifo_count;

    uart_char_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .char_in      (char_in),
        .char_valid   (char_valid),
        .overflow_clr (overflow_clr),
        .tx           (tx),
        .busy         (busy),
        .overflow     (overflow),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a character queue plus "cycles since the current
    // frame started"; the line value is looked up in the 10-bit frame.
    logic [7:0] mq[$];
    bit         m_active;
    int         m_t;
    logic [9:0] m_frame;
    bit         m_ovf;

    function automatic void model_reset();
        mq.delete();
        m_active = 0;
        m_t      = 0;
        m_ovf    = 0;
    endfunction

    function automatic void model_edge(input bit v, input logic [7:0] ch, input bit clr);
        bit pop_now;
        bit drop;
        pop_now = (mq.size() > 0) && (!m_active || m_t == FLEN-1);
        drop    = v && !((mq.size() < DEPTH) || pop_now);
        if (pop_now) begin
            m_frame  = {1'b1, mq.pop_front(), 1'b0};
            m_t      = 0;
            m_active = 1;
        end else if (m_active) begin
            m_t++;
            if (m_t == FLEN) m_active = 0;
        end
        if (v && !drop) mq.push_back(ch);
        if (drop)     m_ovf = 1;
        else if (clr) m_ovf = 0;
    endfunction

    function automatic void check_model(input string tag);
        logic etx;
        etx = m_active ? m_frame[m_t / CD] : 1'b1;
        chk({tag, "_tx"},    tx,         etx);
        chk({tag, "_busy"},  busy,       m_active);
        chk({tag, "_ovf"},   overflow,   m_ovf);
        chk({tag, "_count"}, fifo_count, mq.size());
    endfunction

    task automatic step(input bit v, input logic [7:0] ch, input bit clr);
        @(negedge clk);
        char_valid   = v;
        char_in      = ch;
        overflow_clr = clr;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(v, ch, clr);
        #1;
        check_model("model");
    endtask

    typedef struct {
        string      name;
        bit         v;
        logic [7:0] ch;
        int         cycles;
        logic       exp_tx;
        logic       exp_busy;
        int         exp_cnt;
    } vec_t;

    vec_t       tbl[13];
    logic       line[$];
    logic [7:0] dec;
    int         bad;

    initial begin
        // 0x41 = 0100_0001, sent LSB first.
        tbl[0]  = '{"push",  1'b1, 8'h41, 1, 1'b1, 1'b0, 1};
        tbl[1]  = '{"start", 1'b0, 8'h00, 4, 1'b0, 1'b1, 0};
        tbl[2]  = '{"d0",    1'b0, 8'h00, 4, 1'b1, 1'b1, 0};
        tbl[3]  = '{"d1",    1'b0, 8'h00, 4, 1'b0, 1'b1, 0};
        tbl[4]  = '{"d2",    1'b0, 8'h00, 4, 1'b0, 1'b1, 0};
        tbl[5]  = '{"d3",    1'b0, 8'h00, 4, 1'b0, 1'b1, 0};
        tbl[6]  = '{"d4",    1'b0, 8'h00, 4, 1'b0, 1'b1, 0};
        tbl[7]  = '{"d5",    1'b0, 8'h00, 4, 1'b0, 1'b1, 0};
        tbl[8]  = '{"d6",    1'b0, 8'h00, 4, 1'b1, 1'b1, 0};
        tbl[9]  = '{"d7",    1'b0, 8'h00, 4, 1'b0, 1'b1, 0};
        tbl[10] = '{"stop",  1'b0, 8'h00, 4, 1'b1, 1'b1, 0};
        tbl[11] = '{"idle",  1'b0, 8'h00, 2, 1'b1, 1'b0, 0};
        tbl[12] = '{"idle2", 1'b0, 8'h00, 1, 1'b1, 1'b0, 0};

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_count", fifo_count, 0);
        step(1'b1, 8'h99, 1'b0);   // ignored while in reset
        step(1'b0, 8'h00, 1'b0);
        chk("rst_hold_count", fifo_count, 0);
        rst = 1'b0;
        repeat (3) step(1'b0, 8'h00, 1'b0);

        // Single character, table-driven.
        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].cycles; c++) begin
                step(tbl[i].v && (c == 0), tbl[i].ch, 1'b0);
                chk($sformatf("single_%s_tx", tbl[i].name), tx, tbl[i].exp_tx);
                chk($sformatf("single_%s_busy", tbl[i].name), busy, tbl[i].exp_busy);
                chk($sformatf("single_%s_cnt", tbl[i].name), fifo_count, tbl[i].exp_cnt);
            end
        end

        // Back-to-back: line[j] holds tx just after edge E(1+j).
        step(1'b1, 8'h55, 1'b0);
        line.delete();
        bad = 0;
        step(1'b1, 8'hAA, 1'b0);
        line.push_back(tx);
        for (int j = 1; j < 82; j++) begin
            step(1'b0, 8'h00, 1'b0);
            line.push_back(tx);
            if (j < 80 && busy !== 1'b1) bad++;
            if (j == 80) chk("b2b_busy_end", busy, 1'b0);
        end
        chk("b2b_busy_gapless", bad, 0);
        chk("b2b_stop_before_2nd", line[39], 1'b1);
        chk("b2b_2nd_start", line[40], 1'b0);
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < 8; b++) dec[b] = line[f*FLEN + CD*(1+b) + CD/2];
            chk($sformatf("b2b_start%0d", f), line[f*FLEN + CD/2], 1'b0);
            chk($sformatf("b2b_stop%0d", f), line[f*FLEN + CD*9 + CD/2], 1'b1);
            chk($sformatf("b2b_byte%0d", f), dec, (f == 0) ? 8'h55 : 8'hAA);
        end

        // Overflow: chars 01..06 on consecutive edges, 06 dropped.
        repeat (5) step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'(i+1), 1'b0);
            if (i == 4) chk("ovf_before_drop", overflow, 1'b0);
        end
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_peak_count", fifo_count, 4);
        step(1'b1, 8'h07, 1'b1);
        chk("ovf_clr_race", overflow, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("ovf_clr", overflow, 1'b0);
        repeat (5*FLEN + 10) step(1'b0, 8'h00, 1'b0);
        chk("ovf_drain_count", fifo_count, 0);
        chk("ovf_drain_busy", busy, 1'b0);

        // Randomised traffic: sparse then dense.
        for (int i = 0; i < 3000; i++) begin
            step((i < 1500) ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 7) == 0),
                 8'($urandom), $urandom_range(0, 39) == 0);
        end
        repeat (DEPTH*FLEN + 2*FLEN) step(1'b0, 8'h00, 1'b0);

        // Reset during data bit 3 with two characters queued.
        step(1'b1, 8'h41, 1'b0);
        step(1'b1, 8'h42, 1'b0);
        step(1'b1, 8'h43, 1'b0);
        repeat (16) step(1'b0, 8'h00, 1'b0);   // now just after E18
        chk("midrst_pre_count", fifo_count, 2);
        chk("midrst_pre_busy", busy, 1'b1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_count", fifo_count, 0);
        step(1'b1, 8'h44, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("midrst_quiet", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
